wb_gpio_led: RTL and testbench

Wishbone classic slave on the SoC data bus for board I/O: the 8-bit bidirectional IO header and the 4 user LEDs. It sits directly downstream of the SoC's Wishbone master port in the board top. It provides:
- per-pin output data and output enable;
- synchronized input sampling with rising-edge interrupt capture;
- LED drive with per-LED hardware blink from a free-running prescaler.

---
 rtl/wb_gpio_led.sv | 144 ++++++++++++++
 tb/tb_wb_gpio_led.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_led.sv
// Wishbone classic slave for the board IO header and user LEDs: pin output/enable,
// synchronized inputs with rising-edge interrupt capture, and per-LED hardware blink.
module wb_gpio_led #(
  parameter int ADDR_WIDTH = 5,
  parameter int BLINK_DIV  = 12000000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [7:0]            gpio_i,
  output logic [7:0]            gpio_o,
  output logic [7:0]            gpio_oe_o,
  output logic [3:0]            led_o,
  output logic                  irq_o
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  localparam logic [2:0] REG_OUT   = 3'd0;
  localparam logic [2:0] REG_OE    = 3'd1;
  localparam logic [2:0] REG_IN    = 3'd2;
  localparam logic [2:0] REG_LED   = 3'd3;
  localparam logic [2:0] REG_BLINK = 3'd4;
  localparam logic [2:0] REG_IE    = 3'd5;
  localparam logic [2:0] REG_IS    = 3'd6;

  logic [7:0]       out_data;
  logic [7:0]       out_en;
  logic [3:0]       led_val;
  logic [3:0]       blink_en;
  logic [7:0]       irq_en;
  logic [7:0]       irq_stat;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       prev;
  logic             irq;
  logic             ack;
  logic [31:0]      dat;
  logic [CNT_W-1:0] cnt;
  logic             phase;

  logic             req;
  logic             in_range;
  logic             wr;
  logic [2:0]       idx;
  logic [7:0]       wdata;
  logic [7:0]       rdata;
  logic [7:0]       rise;
  logic [7:0]       w1c;
  logic [7:0]       irq_stat_next;
  logic             unused_bits;

  // A new request is only taken while ack is low, giving one ack per two cycles.
  assign req      = wb_cyc_i & wb_stb_i & ~ack;
  assign in_range = (wb_adr_i >> 5) == '0;
  assign idx      = wb_adr_i[4:2];
  assign wdata    = wb_dat_i[7:0];
  assign wr       = req & wb_we_i & wb_sel_i[0] & in_range;
  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

  assign rise = sync2 & ~prev;
  assign w1c  = (wr && idx == REG_IS) ? wdata : 8'h00;
  // Edge set is OR-ed in after the clear so a coincident set survives.
  assign irq_stat_next = (irq_stat & ~w1c) | (rise & irq_en);

  always_comb begin
    rdata = 8'h00;
    if (in_range) begin
      case (idx)
        REG_OUT:   rdata = out_data;
        REG_OE:    rdata = out_en;
        REG_IN:    rdata = sync2;
        REG_LED:   rdata = {4'h0, led_val};
        REG_BLINK: rdata = {4'h0, blink_en};
        REG_IE:    rdata = irq_en;
        REG_IS:    rdata = irq_stat;
        default:   rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      out_data <= 8'h00;
      out_en   <= 8'h00;
      led_val  <= 4'h0;
      blink_en <= 4'h0;
      irq_en   <= 8'h00;
      irq_stat <= 8'h00;
      sync1    <= 8'h00;
      sync2    <= 8'h00;
      prev     <= 8'h00;
      irq      <= 1'b0;
      ack      <= 1'b0;
      dat      <= 32'h0;
      cnt      <= '0;
      phase    <= 1'b0;
    end else begin
      ack <= req;
      dat <= req ? {24'h0, rdata} : 32'h0;

      if (wr) begin
        case (idx)
          REG_OUT:   out_data <= wdata;
          REG_OE:    out_en   <= wdata;
          REG_LED:   led_val  <= wdata[3:0];
          REG_BLINK: blink_en <= wdata[3:0];
          REG_IE:    irq_en   <= wdata;
          default:   ;
        endcase
      end

      // Two-flop synchronizer, then one more stage for edge detection.
      sync1    <= gpio_i;
      sync2    <= sync1;
      prev     <= sync2;
      irq_stat <= irq_stat_next;
      irq      <= |(irq_stat & irq_en);

      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign wb_ack_o  = ack;
  assign wb_dat_o  = dat;
  assign gpio_o    = out_data;
  assign gpio_oe_o = out_en;
  assign led_o     = led_val ^ (blink_en & {4{phase}});
  assign irq_o     = irq;

endmodule

// File: tb/tb_wb_gpio_led.sv
// Directed bench for wb_gpio_led: register table, ack cadence, interrupt path,
// set/clear race, blink waveform and asynchronous reset during a transfer.
module tb_wb_gpio_led;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic [3:0]  led;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_gpio_led #(.ADDR_WIDTH(5), .BLINK_DIV(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat_r), .wb_ack_o(ack), .gpio_i(gpio_in), .gpio_o(gpio_out),
    .gpio_oe_o(gpio_oe), .led_o(led), .irq_o(irq)
  );

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
    logic [7:0]  exp_oe;
    logic [3:0]  exp_led;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the ack cycle plus one idle edge.
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int lat;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    check("ack_latency", 32'(lat), 32'd1);
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus(1'b1, a, d, 4'b0001, rd);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, a, 32'h0, 4'b0001, rd);
    check(name, rd, exp);
  endtask

  vec_t vt[15];

  initial begin
    logic [31:0] rd;
    logic [3:0]  s[24];
    logic [3:0]  base;
    logic [3:0]  exp_led;
    int          k;

    vt[0]  = '{1'b1, 5'h00, 32'h000000A5, 4'b0001, 32'h0,  8'hA5, 8'h00, 4'h0};
    vt[1]  = '{1'b1, 5'h04, 32'h0000000F, 4'b0001, 32'h0,  8'hA5, 8'h0F, 4'h0};
    vt[2]  = '{1'b1, 5'h00, 32'h000000FF, 4'b0010, 32'h0,  8'hA5, 8'h0F, 4'h0};
    vt[3]  = '{1'b0, 5'h00, 32'h0,        4'b0001, 32'hA5, 8'hA5, 8'h0F, 4'h0};
    vt[4]  = '{1'b0, 5'h04, 32'h0,        4'b0001, 32'h0F, 8'hA5, 8'h0F, 4'h0};
    vt[5]  = '{1'b1, 5'h00, 32'hFFFFFF3C, 4'b1111, 32'h0,  8'h3C, 8'h0F, 4'h0};
    vt[6]  = '{1'b0, 5'h00, 32'h0,        4'b0001, 32'h3C, 8'h3C, 8'h0F, 4'h0};
    vt[7]  = '{1'b1, 5'h1C, 32'h000000FF, 4'b0001, 32'h0,  8'h3C, 8'h0F, 4'h0};
    vt[8]  = '{1'b0, 5'h1C, 32'h0,        4'b0001, 32'h0,  8'h3C, 8'h0F, 4'h0};
    vt[9]  = '{1'b1, 5'h08, 32'h000000FF, 4'b0001, 32'h0,  8'h3C, 8'h0F, 4'h0};
    vt[10] = '{1'b0, 5'h08, 32'h0,        4'b0001, 32'h0,  8'h3C, 8'h0F, 4'h0};
    vt[11] = '{1'b1, 5'h0C, 32'h000000FA, 4'b0001, 32'h0,  8'h3C, 8'h0F, 4'hA};
    vt[12] = '{1'b0, 5'h0C, 32'h0,        4'b0001, 32'h0A, 8'h3C, 8'h0F, 4'hA};
    vt[13] = '{1'b1, 5'h0C, 32'h00000000, 4'b0001, 32'h0,  8'h3C, 8'h0F, 4'h0};
    vt[14] = '{1'b0, 5'h10, 32'h0,        4'b0001, 32'h0,  8'h3C, 8'h0F, 4'h0};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 5'h0;
    dat_w = 32'h0; sel = 4'h0; gpio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", dat_r, 32'h0);
    check("rst_gpio_o", {24'h0, gpio_out}, 32'h0);
    check("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rd_chk("rst_read", 5'(i * 4), 32'h0);

    for (int i = 0; i < 15; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd);
      if (!vt[i].we) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_gpio", i), {24'h0, gpio_out}, {24'h0, vt[i].exp_gpio});
      check($sformatf("vec%0d_oe", i), {24'h0, gpio_oe}, {24'h0, vt[i].exp_oe});
      check($sformatf("vec%0d_led", i), {28'h0, led}, {28'h0, vt[i].exp_led});
    end

    // Held strobe: ack pulses every other cycle.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h00; sel = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack%0d", i), {31'h0, ack}, {31'h0, 1'(i % 2)});
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("held_ack_end", {31'h0, ack}, 32'h0);
    check("held_dat_idle", dat_r, 32'h0);

    // Interrupt path latency.
    wr(5'h14, 32'h81);
    gpio_in = 8'h83;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("irq_edge%0d", i), {31'h0, irq}, {31'h0, 1'(i == 4)});
    end
    rd_chk("in_read", 5'h08, 32'h83);
    rd_chk("is_read", 5'h18, 32'h81);
    wr(5'h18, 32'h01);
    rd_chk("is_after_w1c0", 5'h18, 32'h80);
    check("irq_still_set", {31'h0, irq}, 32'h1);
    wr(5'h18, 32'h80);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    rd_chk("is_cleared", 5'h18, 32'h00);

    // Falling edges do not set status; then race an edge set with a W1C.
    gpio_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    rd_chk("is_no_fall", 5'h18, 32'h00);
    gpio_in = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    wr(5'h18, 32'h01);
    rd_chk("is_set_wins", 5'h18, 32'h01);
    wr(5'h18, 32'h01);
    check("irq_after_race_clear", {31'h0, irq}, 32'h0);

    // Blink with BLINK_DIV = 4.
    wr(5'h0C, 32'h5);
    wr(5'h10, 32'h3);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      s[i] = led;
    end
    k = 1;
    for (int i = 5; i >= 1; i--) if (s[i] != s[i-1]) k = i;
    base = s[k];
    check("blink_hi_bits", {30'h0, base[3:2]}, 32'h1);
    check("blink_lo_bits", {31'h0, base[1] ^ base[0]}, 32'h1);
    for (int i = k; i < k + 16; i++) begin
      exp_led = (((i - k) / 4) % 2 == 1) ? (base ^ 4'h3) : base;
      check($sformatf("blink%0d", i), {28'h0, s[i]}, {28'h0, exp_led});
    end

    // Asynchronous reset while a write to LED is being acked.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h0C; dat_w = 32'hF; sel = 4'b0001;
    @(posedge clk); #2;
    check("mid_ack_high", {31'h0, ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'h0, ack}, 32'h0);
    check("mid_rst_led", {28'h0, led}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("led_after_rst", 5'h0C, 32'h0);
    rd_chk("blink_after_rst", 5'h10, 32'h0);
    check("led_out_after_rst", {28'h0, led}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
